// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Arbitrates NUM_REQ write requesters onto the single registered write port
// of a register file. The grant is round-robin: the search starts at rr_ptr
// and wraps, so after a transfer the winner becomes the lowest priority.
// An optional clear sequence zero-fills registers 0..REG_COUNT-1, one per
// cycle. While it runs, the sequence has priority over all requesters.
//
// Optional feature macro: REGFILE_ARB_CLEAR_EN
//   defined   : CLEAR state, sweep counter and clear_i behaviour are built
//   undefined : no CLEAR state, clear_i ignored, busy_o tied low
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        asynchronous reset, active-high
//   req_valid_i  per-requester write request
//   req_addr_i   packed addresses, requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data_i   packed write data, same packing
//   req_ready_o  one-hot accept (combinational)
//   clear_i      start zero-fill of all registers
//   busy_o       clear sequence in progress
//   we_o         registered write enable
//   waddr_o      registered write address
//   wdata_o      registered write data
//   grant_id_o   registered index of the requester behind the current write
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          clear_i,
  output logic                          busy_o,
  output logic                          we_o,
  output logic [ADDR_WIDTH-1:0]         waddr_o,
  output logic [DATA_WIDTH-1:0]         wdata_o,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id_o
);

  localparam int ID_W = $clog2(NUM_REQ);

  // Unpacked views of the packed request buses, indexed by requester
  logic [ADDR_WIDTH-1:0] req_addr [NUM_REQ];
  logic [DATA_WIDTH-1:0] req_data [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_addr[k] = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign req_data[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       rr_ptr_next;
  logic [ID_W-1:0]       winner;
  logic                  found;
  logic                  arb_en;
  logic                  transfer;
  logic                  we_next;
  logic [ADDR_WIDTH-1:0] waddr_next;
  logic [DATA_WIDTH-1:0] wdata_next;
  logic [ID_W-1:0]       grant_next;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping
  always_comb begin : rr_search
    int              idx;
    logic [ID_W-1:0] cand;
    idx    = 0;
    cand   = '0;
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (!found && req_valid_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign transfer = arb_en & found;

  // Only the winner sees ready, and only when arbitration is enabled
  always_comb begin
    req_ready_o = '0;
    if (transfer) req_ready_o[winner] = 1'b1;
  end

`ifdef REGFILE_ARB_CLEAR_EN

  typedef enum logic {ARB, CLEAR} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(REG_COUNT - 1);

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [ADDR_WIDTH-1:0] cnt_next;

  // The first sweep write is launched on the edge that enters CLEAR, so
  // clr_cnt always equals the address shown on waddr_o while busy_o is high.
  // The last CLEAR cycle shows address REG_COUNT-1 and arbitration resumes
  // right after it.
  always_comb begin
    state_next  = state;
    cnt_next    = clr_cnt;
    rr_ptr_next = rr_ptr;
    we_next     = 1'b0;
    waddr_next  = waddr_o;
    wdata_next  = wdata_o;
    grant_next  = grant_id_o;
    arb_en      = 1'b0;
    busy_o      = (state == CLEAR);
    case (state)
      ARB: begin
        if (clear_i) begin
          state_next = CLEAR;
          cnt_next   = '0;
          we_next    = 1'b1;
          waddr_next = '0;
          wdata_next = '0;
        end else begin
          arb_en = 1'b1;
          if (found) begin
            we_next     = 1'b1;
            waddr_next  = req_addr[winner];
            wdata_next  = req_data[winner];
            grant_next  = winner;
            rr_ptr_next = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
          end
        end
      end
      CLEAR: begin
        if (clr_cnt == LAST_ADDR) begin
          state_next = ARB;
          cnt_next   = '0;
        end else begin
          cnt_next   = clr_cnt + 1'b1;
          we_next    = 1'b1;
          waddr_next = clr_cnt + 1'b1;
          wdata_next = '0;
        end
      end
      default: state_next = ARB;
    endcase
  end

  // State, pointer and write-port registers; reset aborts any sweep
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ARB;
      clr_cnt    <= '0;
      rr_ptr     <= '0;
      we_o       <= 1'b0;
      waddr_o    <= '0;
      wdata_o    <= '0;
      grant_id_o <= '0;
    end else begin
      state      <= state_next;
      clr_cnt    <= cnt_next;
      rr_ptr     <= rr_ptr_next;
      we_o       <= we_next;
      waddr_o    <= waddr_next;
      wdata_o    <= wdata_next;
      grant_id_o <= grant_next;
    end
  end

`else

  // Without the clear feature clear_i has no effect
  logic unused_clear;
  assign unused_clear = clear_i;
  assign busy_o       = 1'b0;

  // Arbitration is always enabled; write port loads only on a transfer
  always_comb begin
    rr_ptr_next = rr_ptr;
    we_next     = 1'b0;
    waddr_next  = waddr_o;
    wdata_next  = wdata_o;
    grant_next  = grant_id_o;
    arb_en      = 1'b1;
    if (found) begin
      we_next     = 1'b1;
      waddr_next  = req_addr[winner];
      wdata_next  = req_data[winner];
      grant_next  = winner;
      rr_ptr_next = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
    end
  end

  // Pointer and write-port registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr     <= '0;
      we_o       <= 1'b0;
      waddr_o    <= '0;
      wdata_o    <= '0;
      grant_id_o <= '0;
    end else begin
      rr_ptr     <= rr_ptr_next;
      we_o       <= we_next;
      waddr_o    <= waddr_next;
      wdata_o    <= wdata_next;
      grant_id_o <= grant_next;
    end
  end

`endif

endmodule
